// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
// pool_pkg : shared types, sizing helpers and the combine operator for the
//            2x2 pooling stage.  Optional macro POOL_AVG_EN selects averaging.
// Revision : 1.0  initial release
// ============================================================================
package pool_pkg;

  localparam int POOL_DATA_W = 16;

`ifdef POOL_AVG_EN
  localparam int POOL_ACC_EXTRA = 2;
`else
  localparam int POOL_ACC_EXTRA = 0;
`endif

  // Wide scratch type so one combine function serves any DATA_W.
  localparam int POOL_CALC_W = 64;

  typedef logic signed [POOL_DATA_W+POOL_ACC_EXTRA-1:0] pool_acc_t;
  typedef logic signed [POOL_CALC_W-1:0]                pool_calc_t;

  function automatic int out_dim(input int in_dim);
    return in_dim / 2;
  endfunction

  function automatic pool_calc_t pool_combine(input pool_calc_t a, input pool_calc_t b);
`ifdef POOL_AVG_EN
    return a + b;
`else
    return (a > b) ? a : b;
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_line_buf.sv
`default_nettype none
// ============================================================================
// pool_line_buf : half-row buffer of horizontal pair results, written on even
//                 rows and read combinationally on odd rows.
// Revision      : 1.0  initial release
// ============================================================================
module pool_line_buf #(
  parameter int DEPTH  = 2,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [WIDTH-1:0]  rd_data
);

  logic signed [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (int'(wr_addr) == i) r_mem[i] <= wr_data;
      end
    end
  end

  // Mux form keeps a non-power-of-two depth from indexing past the array.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(rd_addr) == i) rd_data = r_mem[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/max_pool_2x2.sv
`default_nettype none
// ============================================================================
// max_pool_2x2 : streaming 2x2 / stride-2 pooling of a raster conv stream.
//                Define POOL_AVG_EN for average pooling instead of max.
// Revision     : 1.0  initial release
// ============================================================================
module max_pool_2x2
  import pool_pkg::*;
#(
  parameter int IN_DIM = 5,
  parameter int DATA_W = POOL_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic                     busy
);

  localparam int OUT_DIM   = out_dim(IN_DIM);
  localparam int POOL_SPAN = 2 * OUT_DIM;
  localparam int CNT_W     = (IN_DIM > 2) ? $clog2(IN_DIM) : 1;
  localparam int ADDR_W    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int ACC_W     = DATA_W + POOL_ACC_EXTRA;

  typedef logic signed [ACC_W-1:0] acc_t;

  logic [CNT_W-1:0]  r_col;
  logic [CNT_W-1:0]  r_row;
  acc_t              r_pair;
  logic              r_busy;

  logic              w_in_pool;
  logic              w_col_end;
  logic              w_row_end;
  logic              w_wr_en;
  logic              w_out_fire;
  logic              w_last_fire;
  logic              w_frame_first;
  logic [ADDR_W-1:0] w_addr;
  acc_t              w_in_ext;
  acc_t              w_pm;
  acc_t              w_buf_rd;
  acc_t              w_res;
  logic signed [DATA_W-1:0] w_out_next;

  assign w_in_ext      = acc_t'(in_data);
  assign w_in_pool     = (int'(r_col) < POOL_SPAN) && (int'(r_row) < POOL_SPAN);
  assign w_col_end     = (int'(r_col) == IN_DIM - 1);
  assign w_row_end     = (int'(r_row) == IN_DIM - 1);
  assign w_wr_en       = in_valid && w_in_pool && r_col[0] && !r_row[0];
  assign w_out_fire    = in_valid && w_in_pool && r_col[0] && r_row[0];
  assign w_last_fire   = w_out_fire && (int'(r_col) == POOL_SPAN - 1)
                                    && (int'(r_row) == POOL_SPAN - 1);
  assign w_frame_first = in_valid && (r_col == '0) && (r_row == '0);
  assign w_addr        = ADDR_W'(r_col >> 1);

  assign w_pm  = acc_t'(pool_combine(POOL_CALC_W'(r_pair), POOL_CALC_W'(w_in_ext)));
  assign w_res = acc_t'(pool_combine(POOL_CALC_W'(w_pm),   POOL_CALC_W'(w_buf_rd)));

`ifdef POOL_AVG_EN
  assign w_out_next = DATA_W'(w_res >>> 2);
`else
  assign w_out_next = DATA_W'(w_res);
`endif

  // A sample accepted at (0,0) keeps busy up even in the out_last cycle.
  assign busy = r_busy || w_frame_first;

  pool_line_buf #(
    .DEPTH  (OUT_DIM),
    .WIDTH  (ACC_W),
    .ADDR_W (ADDR_W)
  ) u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_wr_en),
    .wr_addr (w_addr),
    .wr_data (w_pm),
    .rd_addr (w_addr),
    .rd_data (w_buf_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_row     <= '0;
      r_pair    <= '0;
      r_busy    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= w_out_fire;
      out_last  <= w_last_fire;
      if (w_out_fire) out_data <= w_out_next;

      if (w_frame_first)    r_busy <= 1'b1;
      else if (w_last_fire) r_busy <= 1'b0;

      if (in_valid) begin
        if (!r_col[0]) r_pair <= w_in_ext;
        if (w_col_end) begin
          r_col <= '0;
          r_row <= w_row_end ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_max_pool_2x2.sv
`default_nettype none
// ============================================================================
// tb_max_pool_2x2 : random and directed frames checked every cycle against a
//                   frame-array reference model, plus literal output sequences.
// Revision        : 1.0  initial release
// ============================================================================
module tb_max_pool_2x2;

  localparam int IN_DIM  = 5;
  localparam int DATA_W  = 16;
  localparam int OUT_DIM = IN_DIM / 2;
  localparam int FRAME   = IN_DIM * IN_DIM;

  logic                     clk      = 1'b0;
  logic                     rst_n    = 1'b0;
  logic                     in_valid = 1'b0;
  logic signed [DATA_W-1:0] in_data  = '0;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;
  logic                     busy;

  int n_tests = 0;
  int n_fail  = 0;

  max_pool_2x2 #(.IN_DIM(IN_DIM), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: whole frame kept in an array, pooled window read back.
  int   fr [FRAME];
  int   m_k    = 0;
  int   m_r    = 0;
  int   m_c    = 0;
  logic m_ov   = 1'b0;
  int   m_od   = 0;
  logic m_ol   = 1'b0;
  logic m_busy = 1'b0;

  function automatic int pool4(int a, int b, int c, int d);
`ifdef POOL_AVG_EN
    return (a + b + c + d) >>> 2;
`else
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0; m_ov = 1'b0; m_od = 0; m_ol = 1'b0; m_busy = 1'b0;
    end else begin
      m_ov = 1'b0;
      m_ol = 1'b0;
      if (in_valid) begin
        m_r = m_k / IN_DIM;
        m_c = m_k % IN_DIM;
        fr[m_k] = int'(in_data);
        if (m_k == 0) m_busy = 1'b1;
        if ((m_r % 2 == 1) && (m_c % 2 == 1) && (m_r < 2*OUT_DIM) && (m_c < 2*OUT_DIM)) begin
          m_ov = 1'b1;
          m_od = pool4(fr[m_k-IN_DIM-1], fr[m_k-IN_DIM], fr[m_k-1], fr[m_k]);
          m_ol = (m_r == 2*OUT_DIM-1) && (m_c == 2*OUT_DIM-1);
          if (m_ol) m_busy = 1'b0;
        end
        m_k = (m_k + 1) % FRAME;
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  int got[$];
  int n_last = 0;

  always @(negedge clk) begin
    chk("out_valid", int'(out_valid), int'(m_ov));
    chk("out_data",  int'(out_data),  m_od);
    chk("out_last",  int'(out_last),  int'(m_ol));
    chk("busy",      int'(busy),      int'(m_busy || (in_valid && m_k == 0)));
    if (out_valid) begin
      got.push_back(int'(out_data));
      if (out_last) n_last++;
    end
  end

  task automatic expect_seq(string name, int exp[$], int exp_last);
    chk({name, " count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
    chk({name, " last"}, n_last, exp_last);
    got.delete();
    n_last = 0;
  endtask

  int dat [FRAME];

  task automatic put(int d);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = DATA_W'($urandom);
    end
  endtask

  // mode 0: contiguous, 1: conv-style gaps, 2: random drops
  task automatic send_frame(int mode, int n);
    for (int k = 0; k < n; k++) begin
      if (mode == 1 && k > 0 && k % 3 == 0) idle(2);
      if (mode == 2) idle($urandom_range(0, 2));
      put(dat[k]);
    end
  endtask

  task automatic fill_ramp(int base);
    for (int k = 0; k < FRAME; k++) dat[k] = base + k;
  endtask

  int q[$];

  initial begin
    idle(3);
    rst_n = 1'b1;

    fill_ramp(0);
    send_frame(0, FRAME); idle(4);
`ifdef POOL_AVG_EN
    q = {3, 5, 13, 15};
`else
    q = {6, 8, 16, 18};
`endif
    expect_seq("ramp", q, 1);

    send_frame(1, FRAME); idle(4);
    expect_seq("gaps", q, 1);
    send_frame(2, FRAME); idle(4);
    expect_seq("drops", q, 1);

    for (int k = 0; k < FRAME; k++) dat[k] = -3;
    send_frame(0, FRAME); idle(4);
    q = {-3, -3, -3, -3};
    expect_seq("neg", q, 1);

    for (int k = 0; k < FRAME; k++) dat[k] = 0;
    dat[0] = -1;
    send_frame(2, FRAME); idle(4);
`ifdef POOL_AVG_EN
    q = {-1, 0, 0, 0};
`else
    q = {0, 0, 0, 0};
`endif
    expect_seq("floor", q, 1);

    fill_ramp(0);   send_frame(0, FRAME);
    fill_ramp(100); send_frame(0, FRAME); idle(4);
`ifdef POOL_AVG_EN
    q = {3, 5, 13, 15, 103, 105, 113, 115};
`else
    q = {6, 8, 16, 18, 106, 108, 116, 118};
`endif
    expect_seq("b2b", q, 2);

    fill_ramp(0);
    send_frame(0, 12);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    idle(3);
    rst_n = 1'b1;
`ifdef POOL_AVG_EN
    q = {3, 5};
`else
    q = {6, 8};
`endif
    expect_seq("partial", q, 0);
    send_frame(0, FRAME); idle(4);
`ifdef POOL_AVG_EN
    q = {3, 5, 13, 15};
`else
    q = {6, 8, 16, 18};
`endif
    expect_seq("post_rst", q, 1);

    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < FRAME; k++) dat[k] = int'($signed(DATA_W'($urandom)));
      send_frame(2, FRAME);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(4);
    chk("rand last", n_last, 20);
    got.delete();
    n_last = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
